// File: rtl/sss_bin_extractor.sv
// sss_bin_extractor
//
// Captures the SSS subcarriers of one demodulated OFDM symbol from the
// free-running FFT output stream. It then replays them to the SSS detector as
// one AXI-stream packet with backpressure.
//
// Ports
//   clk_i              clock
//   reset_ni           asynchronous active-low reset (synchronous release expected)
//   s_axis_in_tdata    FFT bin, {imag, real}, both signed IN_DW/2
//   s_axis_in_tvalid   bin valid (upstream cannot be stalled)
//   SSS_valid_i        high for every bin of the SSS symbol
//   m_axis_out_tdata   captured bin, unmodified
//   m_axis_out_tuser   BPSK hard decision = sign bit of the real part
//   m_axis_out_tlast   last beat of the packet
//   m_axis_out_tvalid  beat valid
//   m_axis_out_tready  downstream ready
//   busy_o             capture or drain in progress
//   overflow_o         1-cycle pulse: a symbol arrived while draining and was dropped
//   truncated_o        1-cycle pulse: SSS_valid_i fell before the last SSS bin
//
// Output handshake: a beat transfers on every rising edge where
// m_axis_out_tvalid && m_axis_out_tready. Once tvalid is high it stays high,
// and tdata/tuser/tlast stay frozen, until that transfer happens. tvalid never
// depends combinationally on tready.

module sss_bin_extractor #(
    parameter int IN_DW         = 32,
    parameter int FFT_LEN       = 256,
    parameter int SSS_LEN       = 127,
    parameter int SSS_START_BIN = FFT_LEN / 2 - 63
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [IN_DW-1:0] s_axis_in_tdata,
    input  logic             s_axis_in_tvalid,
    input  logic             SSS_valid_i,
    output logic [IN_DW-1:0] m_axis_out_tdata,
    output logic             m_axis_out_tuser,
    output logic             m_axis_out_tlast,
    output logic             m_axis_out_tvalid,
    input  logic             m_axis_out_tready,
    output logic             busy_o,
    output logic             overflow_o,
    output logic             truncated_o
);

    localparam int CNT_W     = $clog2(FFT_LEN);
    localparam int ADDR_W    = $clog2(SSS_LEN);
    localparam int PTR_W     = $clog2(SSS_LEN + 1);
    localparam int RAM_DEPTH = 1 << ADDR_W;

    localparam logic [CNT_W-1:0] FIRST_BIN = CNT_W'(SSS_START_BIN);
    localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(SSS_START_BIN + SSS_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SSS_LEN - 1);
    localparam logic [PTR_W-1:0] DONE_PTR  = PTR_W'(SSS_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // FSM state; kept as a named signal so checkers can observe it directly.
    state_t state;
    state_t state_next;

    // Input side
    logic [CNT_W-1:0]  bin_cnt;
    logic              accept;
    logic              sym_start;
    logic              in_window;
    logic              capturing;
    logic              wr_en;
    logic              last_write;
    logic              cap_done;
    logic [ADDR_W-1:0] wr_addr;

    // Output side
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [IN_DW-1:0]  rd_data;
    logic              out_valid;
    logic              out_last;
    logic              beat_fire;
    logic              load;
    logic              enter_drain;

    // Flag pulses
    logic              overflow_next;
    logic              truncated_next;

    logic [IN_DW-1:0]  mem [0:RAM_DEPTH-1];

    // ------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------
    assign accept = s_axis_in_tvalid && SSS_valid_i;

    // bin_cnt is 0 only for the first accepted bin of a symbol (it clears
    // whenever SSS_valid_i is low). That makes it a gap-tolerant marker for
    // the start of a symbol. It also keeps a symbol that was dropped during
    // DRAIN from being picked up halfway through once DRAIN ends.
    assign sym_start = accept && (bin_cnt == '0);
    assign in_window = (bin_cnt >= FIRST_BIN) && (bin_cnt <= LAST_BIN);
    assign wr_addr   = ADDR_W'(bin_cnt - FIRST_BIN);

    // ------------------------------------------------------------------
    // Output handshake
    // ------------------------------------------------------------------
    assign beat_fire = out_valid && m_axis_out_tready;

    // Prefetch: fetch the next RAM word whenever the output register is empty
    // or is being emptied this cycle. The RAM read register is the output
    // register, so a freed slot is refilled on the same edge and there is no
    // bubble after tready returns.
    assign load    = (state == DRAIN) && (rd_ptr != DONE_PTR) && (!out_valid || beat_fire);
    assign rd_addr = ADDR_W'(rd_ptr);

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        capturing      = 1'b0;
        overflow_next  = 1'b0;
        truncated_next = 1'b0;
        wr_en          = 1'b0;
        last_write     = 1'b0;

        case (state)
            IDLE: begin
                if (sym_start) begin
                    state_next = CAPTURE;
                    capturing  = 1'b1;
                end
            end

            CAPTURE: begin
                // cap_done marks the cycle after the last SSS bin was written.
                // DRAIN starts here, and the first RAM read lands one edge later.
                if (cap_done) begin
                    state_next = DRAIN;
                end else if (!SSS_valid_i) begin
                    state_next     = IDLE;
                    truncated_next = 1'b1;
                end else begin
                    capturing = 1'b1;
                end
            end

            DRAIN: begin
                if (beat_fire && out_last) begin
                    // The return to IDLE is decided first. A symbol whose first
                    // bin arrives in this same cycle is then accepted.
                    state_next = IDLE;
                    if (sym_start) begin
                        state_next = CAPTURE;
                        capturing  = 1'b1;
                    end
                end else if (sym_start) begin
                    overflow_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (capturing && accept && in_window) begin
            wr_en = 1'b1;
            if (bin_cnt == LAST_BIN) begin
                last_write = 1'b1;
            end
        end
    end

    assign enter_drain = (state_next == DRAIN) && (state != DRAIN);

    // ------------------------------------------------------------------
    // Capture buffer: one write port, one registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= s_axis_in_tdata;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= IDLE;
            bin_cnt     <= '0;
            cap_done    <= 1'b0;
            rd_ptr      <= '0;
            rd_data     <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy_o      <= 1'b0;
            overflow_o  <= 1'b0;
            truncated_o <= 1'b0;
        end else begin
            state       <= state_next;
            cap_done    <= last_write;
            busy_o      <= (state_next != IDLE);
            overflow_o  <= overflow_next;
            truncated_o <= truncated_next;

            if (!SSS_valid_i) begin
                bin_cnt <= '0;
            end else if (s_axis_in_tvalid) begin
                bin_cnt <= bin_cnt + CNT_W'(1);
            end

            if (enter_drain) begin
                rd_ptr    <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (load) begin
                rd_data   <= mem[rd_addr];
                rd_ptr    <= rd_ptr + PTR_W'(1);
                out_valid <= 1'b1;
                out_last  <= (rd_ptr == LAST_PTR);
            end else if (beat_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_axis_out_tdata  = rd_data;
    assign m_axis_out_tuser  = rd_data[IN_DW/2-1];
    assign m_axis_out_tlast  = out_last;
    assign m_axis_out_tvalid = out_valid;

endmodule
